// File: rtl/decode_pkg.sv
// Shared definitions for the registered MIPS decode stage: opcodes, the
// decoded-instruction bundle, and the field decoder / immediate extender.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Widest immediate the extender produces; DATA_W must lie in 16..IMM_MAX_W.
  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [15:0] imm16;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_alu;
    logic        is_imm;
    logic        is_branch;
    logic        illegal;
  } decoded_t;

  function automatic logic [IMM_MAX_W-1:0] ext_imm(input logic [15:0] imm16,
                                                   input logic        zero_ext);
    ext_imm = {{(IMM_MAX_W-16){imm16[15] & ~zero_ext}}, imm16};
  endfunction

  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t d;
    d        = '0;
    d.opcode = instr[31:26];
    d.rs     = instr[25:21];
    d.rt     = instr[20:16];
    d.imm16  = instr[15:0];
    case (d.opcode)
      OP_RTYPE: begin
        d.is_alu = 1'b1;
        d.dest   = instr[15:11];
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        d.is_alu = 1'b1;
        d.is_imm = 1'b1;
        d.dest   = d.rt;
      end
      OP_LW: begin
        d.is_load = 1'b1;
        d.dest    = d.rt;
      end
      OP_SW:          d.is_store  = 1'b1;
      OP_BEQ, OP_BNE: d.is_branch = 1'b1;
      default:        d.illegal   = 1'b1;
    endcase
    // Writing r0 is architecturally a no-op, so it never counts as a write.
    d.reg_write = (d.dest != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_load_scoreboard.sv
// Shadow scoreboard of recently issued loads: a shift register of
// {valid, reg} entries plus a hit check for two source registers.
module load_scoreboard #(
  parameter int LOAD_SHADOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       load_valid,
  input  logic [4:0] load_reg,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  output logic       hit
);

  logic [LOAD_SHADOW-1:0]      ent_valid;
  logic [LOAD_SHADOW-1:0][4:0] ent_reg;

  // Shifts every cycle, independent of stalls, so a load's shadow is time-based.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_reg   <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      ent_valid[0] <= load_valid;
      ent_reg[0]   <= load_reg;
      for (int i = 1; i < LOAD_SHADOW; i++) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_reg[i]   <= ent_reg[i-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_SHADOW; i++) begin
      if (ent_valid[i] &&
          ((src_a != 5'd0 && src_a == ent_reg[i]) ||
           (src_b != 5'd0 && src_b == ent_reg[i])))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage between fetch and execute: decodes one
// instruction per cycle into a one-entry output register and stalls load-use.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LOAD_SHADOW = 1,
  parameter bit HAZARD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_dest,
  output logic [DATA_W-1:0] out_imm_ext,
  output logic              out_reg_write,
  output logic              out_is_load,
  output logic              out_is_store,
  output logic              out_is_alu,
  output logic              out_is_imm,
  output logic              out_is_branch,
  output logic              out_illegal
);

  // Handshake: a transfer happens on a clock edge where valid && ready.
  // in_valid/in_instr and out_* must stay stable while valid && !ready;
  // ready may depend combinationally on the data it qualifies (hazard).

  decoded_t   in_dec;
  decoded_t   out_q;
  logic       out_valid_q;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       sb_hit;
  logic       held_hit;
  logic       hazard;
  logic       accept;
  logic       issue;

  always_comb in_dec = decode_instr(in_instr);

  // Illegal instructions read nothing, so they never stall on their own fields.
  always_comb begin
    src_a = 5'd0;
    src_b = 5'd0;
    if (!in_dec.illegal) src_a = in_dec.rs;
    if (in_dec.opcode == OP_RTYPE || in_dec.is_store || in_dec.is_branch)
      src_b = in_dec.rt;
  end

  always_comb begin
    held_hit = out_valid_q && out_q.is_load && out_q.reg_write &&
               ((src_a != 5'd0 && src_a == out_q.dest) ||
                (src_b != 5'd0 && src_b == out_q.dest));
    hazard   = HAZARD_EN && (sb_hit || held_hit);
    in_ready = !flush && (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
    issue    = out_valid_q && out_ready;
  end

  load_scoreboard #(.LOAD_SHADOW(LOAD_SHADOW)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load_valid (issue && out_q.is_load && out_q.reg_write && !flush),
    .load_reg   (out_q.dest),
    .src_a      (src_a),
    .src_b      (src_b),
    .hit        (sb_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= in_dec;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    out_valid     = out_valid_q;
    out_opcode    = out_q.opcode;
    out_rs        = out_q.rs;
    out_rt        = out_q.rt;
    out_dest      = out_q.dest;
    out_imm_ext   = DATA_W'(ext_imm(out_q.imm16,
                                    out_q.opcode == OP_ANDI || out_q.opcode == OP_ORI));
    out_reg_write = out_q.reg_write;
    out_is_load   = out_q.is_load;
    out_is_store  = out_q.is_store;
    out_is_alu    = out_q.is_alu;
    out_is_imm    = out_q.is_imm;
    out_is_branch = out_q.is_branch;
    out_illegal   = out_q.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, extension, load-use stall,
// backpressure, flush, async reset, and a HAZARD_EN=0 instance.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_dest;
  logic [31:0] out_imm_ext;
  logic        out_reg_write;
  logic        out_is_load;
  logic        out_is_store;
  logic        out_is_alu;
  logic        out_is_imm;
  logic        out_is_branch;
  logic        out_illegal;

  logic        nh_in_valid;
  logic        nh_in_ready;
  logic [31:0] nh_in_instr;
  logic        nh_out_valid;
  logic        nh_out_ready;
  logic [5:0]  nh_out_opcode;
  logic [4:0]  nh_out_rs;
  logic [4:0]  nh_out_rt;
  logic [4:0]  nh_out_dest;
  logic [31:0] nh_out_imm_ext;
  logic        nh_out_reg_write;
  logic        nh_out_is_load;
  logic        nh_out_is_store;
  logic        nh_out_is_alu;
  logic        nh_out_is_imm;
  logic        nh_out_is_branch;
  logic        nh_out_illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  decode_stage #(.DATA_W(32), .LOAD_SHADOW(1), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
    .out_imm_ext(out_imm_ext), .out_reg_write(out_reg_write),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_alu(out_is_alu),
    .out_is_imm(out_is_imm), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  decode_stage #(.DATA_W(32), .LOAD_SHADOW(1), .HAZARD_EN(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(nh_in_valid), .in_ready(nh_in_ready), .in_instr(nh_in_instr),
    .out_valid(nh_out_valid), .out_ready(nh_out_ready),
    .out_opcode(nh_out_opcode), .out_rs(nh_out_rs), .out_rt(nh_out_rt),
    .out_dest(nh_out_dest), .out_imm_ext(nh_out_imm_ext),
    .out_reg_write(nh_out_reg_write), .out_is_load(nh_out_is_load),
    .out_is_store(nh_out_is_store), .out_is_alu(nh_out_is_alu),
    .out_is_imm(nh_out_is_imm), .out_is_branch(nh_out_is_branch),
    .out_illegal(nh_out_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // driver tasks (entered and left at posedge+1)
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] instr, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(instr[31:16]);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // scoreboard: every downstream issue must match the next accepted instruction
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("mon_extra", 32'd1, 32'd0);
      else check("mon_order", {16'd0, out_opcode, out_rs, out_rt}, {16'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int st;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    nh_in_valid = 1'b0; nh_in_instr = '0; nh_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dest", {27'd0, out_dest}, 32'd0);
    check("rst_imm", out_imm_ext, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // LW r5, 0x10(r2)
    send(32'h8C450010, st);
    check("lw_valid", {31'd0, out_valid}, 32'd1);
    check("lw_is_load", {31'd0, out_is_load}, 32'd1);
    check("lw_rs", {27'd0, out_rs}, 32'd2);
    check("lw_dest", {27'd0, out_dest}, 32'd5);
    check("lw_imm", out_imm_ext, 32'h00000010);
    check("lw_reg_write", {31'd0, out_reg_write}, 32'd1);

    // ADD r6,r5,r1 directly after: hold cycle + one shadow cycle
    send(32'h00A13020, st);
    check("load_use_stalls", st, 32'd2);
    check("add_dest", {27'd0, out_dest}, 32'd6);
    check("add_is_alu", {31'd0, out_is_alu}, 32'd1);

    send(32'h3022FFFF, st);  // ANDI zero-extends
    check("andi_stalls", st, 32'd0);
    check("andi_imm", out_imm_ext, 32'h0000FFFF);
    check("andi_is_imm", {31'd0, out_is_imm}, 32'd1);
    check("andi_dest", {27'd0, out_dest}, 32'd2);
    send(32'h2022FFFF, st);  // ADDI sign-extends
    check("addi_imm", out_imm_ext, 32'hFFFFFFFF);

    send(32'hAC450004, st);  // SW r5, 4(r2)
    check("sw_is_store", {31'd0, out_is_store}, 32'd1);
    check("sw_dest", {27'd0, out_dest}, 32'd0);
    check("sw_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("sw_imm", out_imm_ext, 32'h00000004);
    send(32'h1022FFFE, st);  // BEQ r1,r2,-2
    check("beq_is_branch", {31'd0, out_is_branch}, 32'd1);
    check("beq_imm", out_imm_ext, 32'hFFFFFFFE);
    send(32'h00220020, st);  // ADD r0,r1,r2
    check("rd0_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("rd0_is_alu", {31'd0, out_is_alu}, 32'd1);

    // illegal opcode 0x3F right after a load to r1 it "reads" via rs
    send(32'h8C010000, st);
    send(32'hFC220000, st);
    check("ill_stalls", st, 32'd0);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_opcode", {26'd0, out_opcode}, 32'h3F);
    check("ill_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("ill_is_alu", {31'd0, out_is_alu}, 32'd0);
    check("ill_dest", {27'd0, out_dest}, 32'd0);
    repeat (3) step();

    // backpressure: hold ORI for 3 cycles with the next instruction waiting
    out_ready = 1'b0;
    send(32'h34A70055, st);
    in_valid = 1'b1;
    in_instr = 32'h00A13020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_opcode", {26'd0, out_opcode}, 32'h0D);
      check("bp_rt", {27'd0, out_rt}, 32'd7);
      check("bp_imm", out_imm_ext, 32'h00000055);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h00A13020, st);
    check("b2b_first", st, 32'd0);
    send(32'hAC450004, st);
    check("b2b_second", st, 32'd0);

    // flush while LW r5 issues and LW r7 sits in the shadow
    send(32'h8C470000, st);
    send(32'h8C450010, st);
    check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00A73020;
    @(negedge clk);
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h00A73020, st);
    check("fl_dep_stalls", st, 32'd0);
    check("fl_dep_dest", {27'd0, out_dest}, 32'd6);
    step();

    // flush kills a held, unissued result
    out_ready = 1'b0;
    send(32'h34220001, st);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_kill_valid", {31'd0, out_valid}, 32'd0);
    void'(exp_q.pop_back());
    out_ready = 1'b1;

    // async reset mid-stall
    send(32'h8C450010, st);
    in_valid = 1'b1;
    in_instr = 32'h00A13020;
    @(negedge clk);
    check("rs_stall", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_is_load", {31'd0, out_is_load}, 32'd0);
    check("rs_dest", {27'd0, out_dest}, 32'd0);
    check("rs_imm", out_imm_ext, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h00A13020, st);
    check("rs_after_stalls", st, 32'd0);

    // HAZARD_EN=0 instance: load-use goes straight through
    nh_in_valid = 1'b1;
    nh_in_instr = 32'h8C450010;
    @(negedge clk);
    check("nh_lw_ready", {31'd0, nh_in_ready}, 32'd1);
    @(posedge clk); #1;
    nh_in_instr = 32'h00A13020;
    @(negedge clk);
    check("nh_no_stall", {31'd0, nh_in_ready}, 32'd1);
    @(posedge clk); #1;
    nh_in_valid = 1'b0;
    check("nh_add_dest", {27'd0, nh_out_dest}, 32'd6);

    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
